swu_ram_fifo_ctrl: RTL and testbench

- Sequencing controller for the dual-port asymmetric (wide-write / narrow-read) buffer RAM in the MMV input sliding-window unit.
- Accepts a wide AXI-Stream input and drives RAM port A writes into a circular buffer.
- Issues sequential narrow reads on port B, absorbs the 1-cycle RAM read latency, and presents a narrow AXI-Stream output in order.
- The RAM is instantiated beside this block on the same clock (clkA = clkB = ap_clk); this block owns all RAM enables and addresses.

---
 rtl/swu_pkg.sv | 15 +
 rtl/swu_out_skid.sv | 37 +++
 rtl/swu_ram_fifo_ctrl.sv | 75 +++++++
 tb/tb_swu_ram_fifo_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swu_pkg.sv
// swu_pkg: default geometry, width ratio and clog2 helper for the sliding-window RAM FIFO
package swu_pkg;
  localparam int DEF_WIDTHA = 16;
  localparam int DEF_WIDTHB = 4;
  localparam int DEF_SIZEA = 256;
  localparam int DEF_ADDRWIDTHB = 10;
  localparam int RATIO = DEF_WIDTHA / DEF_WIDTHB;
  localparam int LEVEL_W = DEF_ADDRWIDTHB + 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/swu_out_skid.sv
// swu_out_skid: two-entry narrow output buffer absorbing the RAM read latency (push/din in, valid/dout/cnt out)
module swu_out_skid import swu_pkg::*; #(
  parameter int W = DEF_WIDTHB
) (
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop_ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt
);
  logic [1:0] cnt_q, cnt_d;
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic pop;
  always_comb begin
    valid = cnt_q != 2'd0;
    dout = e0_q;
    cnt = cnt_q;
    pop = valid && pop_ready;
    cnt_d = flush ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
    e0_d = pop ? (cnt_q == 2'd1 ? din : e1_q) : (cnt_q == 2'd0 ? din : e0_q);
    e1_d = push ? din : e1_q;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      cnt_q <= 2'd0;
      e0_q <= '0;
      e1_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
endmodule

// File: rtl/swu_ram_fifo_ctrl.sv
// swu_ram_fifo_ctrl: wide-write/narrow-read circular buffer sequencer driving an external asymmetric dual-port RAM
module swu_ram_fifo_ctrl import swu_pkg::*; #(
  parameter int WIDTHA = DEF_WIDTHA,
  parameter int WIDTHB = DEF_WIDTHB,
  parameter int SIZEA = DEF_SIZEA,
  parameter int ADDRWIDTHA = clog2(SIZEA),
  parameter int SIZEB = SIZEA * (WIDTHA / WIDTHB),
  parameter int ADDRWIDTHB = clog2(SIZEB)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  flush,
  input  logic [WIDTHA-1:0]     s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [WIDTHB-1:0]     m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  ram_enaA,
  output logic                  ram_weA,
  output logic [ADDRWIDTHA-1:0] ram_addrA,
  output logic [WIDTHA-1:0]     ram_diA,
  output logic                  ram_enaB,
  output logic [ADDRWIDTHB-1:0] ram_addrB,
  input  logic [WIDTHB-1:0]     ram_doB,
  output logic [ADDRWIDTHB:0]   level
);
  localparam int R = WIDTHA / WIDTHB;
  localparam int LW = ADDRWIDTHB + 1;
  logic [ADDRWIDTHA-1:0] wp_q, wp_d;
  logic [ADDRWIDTHB-1:0] rp_q, rp_d;
  logic [LW-1:0] level_q, level_d;
  logic inflight_q, inflight_d, wr, rd, pop;
  logic [1:0] obuf_cnt;
  always_comb begin
    s_tready = ap_rst_n && !flush && level_q <= LW'(SIZEB - R);
    wr = s_tvalid && s_tready;
    pop = m_tvalid && m_tready;
    rd = level_q != '0 && !flush && ({1'b0, obuf_cnt} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});
    wp_d = flush ? '0 : wp_q + ADDRWIDTHA'(wr);
    rp_d = flush ? '0 : rp_q + ADDRWIDTHB'(rd);
    level_d = flush ? '0 : level_q + (wr ? LW'(R) : '0) - LW'(rd);
    inflight_d = rd;
    ram_enaA = wr;
    ram_weA = wr;
    ram_addrA = wp_q;
    ram_diA = s_tdata;
    ram_enaB = rd;
    ram_addrB = rp_q;
    level = level_q;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      level_q <= level_d;
      inflight_q <= inflight_d;
    end
  swu_out_skid #(.W(WIDTHB)) u_skid (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .flush(flush),
    .push(inflight_q),
    .din(ram_doB),
    .pop_ready(m_tready),
    .valid(m_tvalid),
    .dout(m_tdata),
    .cnt(obuf_cnt)
  );
endmodule

// File: tb/tb_swu_ram_fifo_ctrl.sv
// tb_swu_ram_fifo_ctrl: scoreboard bench for swu_ram_fifo_ctrl with a behavioural asymmetric RAM
`timescale 1ns/1ps
module tb_swu_ram_fifo_ctrl;
  import swu_pkg::*;
  logic ap_clk = 1'b0, ap_rst_n = 1'b0, flush = 1'b0, s_tvalid = 1'b0, m_tready = 1'b0;
  logic [15:0] s_tdata = '0;
  logic s_tready, m_tvalid, ram_enaA, ram_weA, ram_enaB;
  logic [3:0] m_tdata, ram_doB = '0, exp_e;
  logic [7:0] ram_addrA;
  logic [15:0] ram_diA;
  logic [9:0] ram_addrB;
  logic [LEVEL_W-1:0] level;
  logic [3:0] mem [1024];
  logic [3:0] exp_q [$];
  int checks = 0, errors = 0, max_level = 0;
  always #5 ap_clk = ~ap_clk;
  swu_ram_fifo_ctrl dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .flush(flush),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .ram_enaA(ram_enaA), .ram_weA(ram_weA), .ram_addrA(ram_addrA), .ram_diA(ram_diA),
    .ram_enaB(ram_enaB), .ram_addrB(ram_addrB), .ram_doB(ram_doB), .level(level)
  );
  always @(posedge ap_clk) begin
    if (ram_enaA && ram_weA)
      for (int i = 0; i < RATIO; i++) mem[{ram_addrA, 2'(i)}] <= ram_diA[i*4 +: 4];
    if (ram_enaB) ram_doB <= mem[ram_addrB];
  end
  always @(negedge ap_clk) if (ap_rst_n) begin
    if (m_tvalid && m_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: got %h with nothing expected", m_tdata);
      end else begin
        exp_e = exp_q.pop_front();
        if (m_tdata !== exp_e) begin
          errors++;
          $display("FAIL sb_data: got %h want %h", m_tdata, exp_e);
        end
      end
    end
    if (s_tvalid && s_tready)
      for (int i = 0; i < RATIO; i++) exp_q.push_back(s_tdata[i*4 +: 4]);
    if (flush) exp_q.delete();
    if (int'(level) > max_level) max_level = int'(level);
  end
  always @(negedge ap_rst_n) exp_q.delete();
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask
  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    m_tready = 1'b1;
    s_tvalid = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge ap_clk);
      if (level == '0 && !m_tvalid && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask
  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({s_tready, m_tvalid, ram_enaA, ram_weA, ram_enaB} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000", {s_tready, m_tvalid, ram_enaA, ram_weA, ram_enaB});
    end
    checks++;
    if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    ap_rst_n = 1'b1;
    #1;
    checks++;
    if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", s_tready); end
    tick();
  endtask
  task automatic test_single();
    logic [15:0] w = 16'hDCBA;
    logic [6:0] expv = 7'b0111100;
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata = w;
    tick();
    s_tvalid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge ap_clk);
      checks++;
      if (m_tvalid !== expv[k]) begin errors++; $display("FAIL single_valid_e%0d: got %b want %b", k, m_tvalid, expv[k]); end
      if (expv[k]) begin
        checks++;
        if (m_tdata !== w[(k-2)*4 +: 4]) begin errors++; $display("FAIL single_data_e%0d: got %h want %h", k, m_tdata, w[(k-2)*4 +: 4]); end
      end
      if (k == 0) begin
        checks++;
        if (level !== 11'd4) begin errors++; $display("FAIL single_level_e0: got %0d want 4", level); end
      end
      if (k == 4) begin
        checks++;
        if (level !== 11'd0) begin errors++; $display("FAIL single_level_e4: got %0d want 0", level); end
      end
    end
    tick();
  endtask
  task automatic test_fill();
    int acc = 0;
    bit bad_ena = 1'b0, ok;
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      s_tdata = 16'($urandom);
      @(negedge ap_clk);
      if (s_tready) acc++;
      if (!s_tready && ram_enaA) bad_ena = 1'b1;
      tick();
    end
    s_tvalid = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (acc != 256) begin errors++; $display("FAIL fill_words: got %0d want 256", acc); end
    checks++;
    if (level !== 11'd1022) begin errors++; $display("FAIL fill_level: got %0d want 1022", level); end
    checks++;
    if ({m_tvalid, s_tready} !== 2'b10) begin errors++; $display("FAIL fill_flags: got %b want 10", {m_tvalid, s_tready}); end
    checks++;
    if (bad_ena) begin errors++; $display("FAIL fill_ena_while_full: got 1 want 0"); end
    tick();
    drain(1300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fill_drain: got stuck want empty"); end
  endtask
  task automatic test_stream();
    int n = 0, outs = 0, gaps = 0;
    bit acc;
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata = {4'(n + 3), 4'(n + 2), 4'(n + 1), 4'(n)};
    for (int c = 0; c < 4000; c++) begin
      @(negedge ap_clk);
      acc = s_tvalid && s_tready;
      if (m_tvalid) outs++;
      else if (outs > 0 && outs < 2400) gaps++;
      if (outs == 2400) break;
      tick();
      if (acc) begin
        n++;
        if (n == 600) s_tvalid = 1'b0;
        else s_tdata = {4'(n + 3), 4'(n + 2), 4'(n + 1), 4'(n)};
      end
    end
    tick();
    checks++;
    if (outs != 2400) begin errors++; $display("FAIL stream_count: got %0d want 2400", outs); end
    checks++;
    if (gaps != 0) begin errors++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stream_leftover: got %0d want 0", exp_q.size()); end
  endtask
  task automatic test_random();
    int n = 0;
    bit acc, ok;
    max_level = 0;
    s_tvalid = 1'b0;
    for (int c = 0; c < 30000 && n < 2000; c++) begin
      m_tready = 1'($urandom_range(0, 1));
      if (!s_tvalid) begin
        s_tvalid = 1'($urandom_range(0, 1));
        s_tdata = 16'($urandom);
      end
      @(negedge ap_clk);
      acc = s_tvalid && s_tready;
      tick();
      if (acc) begin n++; s_tvalid = 1'b0; end
    end
    drain(2500, ok);
    checks++;
    if (n != 2000) begin errors++; $display("FAIL random_words: got %0d want 2000", n); end
    checks++;
    if (!ok) begin errors++; $display("FAIL random_drain: got stuck want empty"); end
    checks++;
    if (max_level > 1024) begin errors++; $display("FAIL random_max_level: got %0d want <=1024", max_level); end
  endtask
  task automatic test_flush();
    logic [15:0] w = 16'h4321;
    int got = 0;
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin s_tdata = 16'($urandom); tick(); end
    s_tvalid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    tick();
    @(negedge ap_clk);
    checks++;
    if (level !== 11'd37 || m_tvalid !== 1'b1) begin errors++; $display("FAIL flush_pre: got level %0d valid %b want 37 1", level, m_tvalid); end
    tick();
    flush = 1'b1;
    m_tready = 1'b1;
    @(negedge ap_clk);
    checks++;
    if ({s_tready, ram_enaB} !== 2'b00) begin errors++; $display("FAIL flush_gate: got %b want 00", {s_tready, ram_enaB}); end
    tick();
    flush = 1'b0;
    m_tready = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (m_tvalid !== 1'b0 || level !== 11'd0) begin errors++; $display("FAIL flush_post: got valid %b level %0d want 0 0", m_tvalid, level); end
    tick();
    s_tvalid = 1'b1;
    s_tdata = w;
    @(negedge ap_clk);
    checks++;
    if (ram_enaA !== 1'b1 || ram_addrA !== 8'd0) begin errors++; $display("FAIL flush_addrA: got en %b addr %0d want 1 0", ram_enaA, ram_addrA); end
    tick();
    s_tvalid = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (ram_enaB !== 1'b1 || ram_addrB !== 10'd0) begin errors++; $display("FAIL flush_addrB: got en %b addr %0d want 1 0", ram_enaB, ram_addrB); end
    tick();
    m_tready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge ap_clk);
      if (m_tvalid) begin
        checks++;
        if (m_tdata !== w[got*4 +: 4]) begin errors++; $display("FAIL flush_word_e%0d: got %h want %h", got, m_tdata, w[got*4 +: 4]); end
        got++;
      end
      tick();
    end
    checks++;
    if (got != 4) begin errors++; $display("FAIL flush_word_count: got %0d want 4", got); end
  endtask
  task automatic test_reset_mid();
    int stale = 0;
    bit ok;
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    for (int c = 0; c < 40; c++) begin s_tdata = 16'($urandom); tick(); end
    #2;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if ({s_tready, m_tvalid, ram_enaA, ram_weA, ram_enaB} !== 5'b0 || level !== '0) begin
      errors++;
      $display("FAIL midrst_async: got %b level %0d want 00000 0", {s_tready, m_tvalid, ram_enaA, ram_weA, ram_enaB}, level);
    end
    s_tvalid = 1'b0;
    tick();
    tick();
    checks++;
    if ({s_tready, m_tvalid, ram_enaB} !== 3'b0) begin errors++; $display("FAIL midrst_hold: got %b want 000", {s_tready, m_tvalid, ram_enaB}); end
    ap_rst_n = 1'b1;
    #1;
    checks++;
    if (s_tready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", s_tready); end
    for (int c = 0; c < 6; c++) begin
      @(negedge ap_clk);
      if (m_tvalid) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL midrst_stale: got %0d want 0", stale); end
    s_tvalid = 1'b1;
    s_tdata = 16'h9E5A;
    tick();
    drain(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_drain: got stuck want empty"); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_random();
    test_flush();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_leftover: got %0d want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
